alu_seq_ctrl: RTL and testbench
===============================

// Module: alu_seq_ctrl
// PURPOSE
//  - Multi-cycle sequencer for the team's four-function ALU (add/sub/mul/div).
//  - Add and sub complete in 1 cycle. Mul and div run as iterative shift-add and restoring-divide loops.
//  - Replaces the wide combinational mul/div arrays with a W-step FSM.
//  - Upstream side is a valid/ready request port; downstream side is a valid/ready result port.
// PARAMETERS
//  - width  6  operand width W; result is 2W bits
// PORTS
//  - clk        in   1       system clock, rising edge
//  - rst_n      in   1       asynchronous active-low reset
//  - in_valid   in   1       request valid
//  - in_ready   out  1       controller can accept a request
//  - a          in   W       operand A (unsigned)
//  - b          in   W       operand B (unsigned)
//  - func       in   2       00 add, 01 sub, 10 mul, 11 div
//  - out_valid  out  1       result valid
//  - out_ready  in   1       consumer accepts result
//  - out        out  2W      result
//  - ovf        out  1       overflow/error flag, qualified by out_valid
// BEHAVIOUR
//  - Reset is async on rst_n low. Every output goes to 0 except in_ready, which goes to 1. FSM goes to IDLE.
//  - States: IDLE, MUL, DIV, DONE. in_ready = (state==IDLE). One op in flight; no overlap.
//  - Accept: in_valid & in_ready at a rising edge. a, b and func are latched; inputs are ignored afterwards.
//  - IDLE -> DONE (add/sub), MUL (func=10) or DIV (func=11) on accept.
//  - Add/sub compute directly into the result register.
//  - MUL/DIV: step counter loads W on accept, decrements each cycle, exits to DONE on the cycle it reaches 1.
//  - Latency is counted from the accept edge to the first edge at which out_valid is 1:
//    - add/sub: 1 cycle
//    - mul/div: W+1 cycles
//  - DONE: out_valid=1. out and ovf are held stable until out_valid & out_ready.
//  - DONE -> IDLE on out_valid & out_ready. out_valid drops next cycle and in_ready rises the same cycle.
//  - Add: out = {W'b0, (a+b)[W-1:0]}; ovf = carry out of bit W-1.
//  - Sub: out = {W'b0, (a-b)[W-1:0]} (mod 2^W); ovf = borrow (a<b).
//  - Mul: shift-add, one multiplier bit per cycle, LSB first. out = a*b (exact 2W bits); ovf=0.
//  - Div: restoring divide with a W+1-bit partial remainder, one quotient bit per cycle, MSB first.
//    - out = {q[W-1:0], r[W-1:0]}; ovf=0 (except the trap case below).
//  - out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
//  - Reset mid-MUL/DIV aborts the op with no result produced. The next accept starts clean.
// CONFIGURATION
//  - Macro: ALU_SEQ_DIV0_TRAP_EN
//  - Defined: div with b==0 skips the DIV loop and goes IDLE -> DONE in 1 cycle with out=0, ovf=1.
//  - Undefined: div with b==0 runs the normal W+1 cycle loop. The natural result is q={W{1}}, r=a, ovf=0.
//  - All other ops are identical in both builds.
// TESTING (width=6)
//  - Add a=50,b=20: out_valid 1 cycle after accept -> out=12'd6, ovf=1. Sub a=5,b=9 -> out=12'd60, ovf=1.
//  - Mul a=63,b=63: out_valid exactly 7 cycles after accept -> out=12'hF81, ovf=0. in_ready=0 throughout.
//  - Div a=45,b=7 -> out={6'd6,6'd3}=12'd387 after 7 cycles, ovf=0.
//    - Div a=5,b=9 -> out={6'd0,6'd5}.
//  - Div a=13,b=0:
//    - trap build: out=0, ovf=1 after 1 cycle
//    - non-trap build: out={6'd63,6'd13}, ovf=0 after 7 cycles
//  - Backpressure: hold out_ready=0 for 5 cycles after mul 3*4 -> out=12 stable, in_valid pulses ignored.
//    - Release: handshake, then in_ready=1 the next cycle.
//  - Assert rst_n=0 on cycle 3 of a mul. Expect:
//    - out_valid=0, out=0, in_ready=1 immediately
//    - after release, add 1+1 -> out=2, ovf=0 after 1 cycle

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer for the four-function ALU: add/sub in one cycle, mul/div as W-step loops.
// Optional macro ALU_SEQ_DIV0_TRAP_EN: divide by zero short-circuits to out=0, ovf=1.
module alu_seq_ctrl #(
  parameter int unsigned width = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [width-1:0]     a,
  input  logic [width-1:0]     b,
  input  logic [1:0]           func,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*width-1:0]   out,
  output logic                 ovf
);

  localparam int unsigned W  = width;
  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_hi;
  logic [W-1:0]    r_lo;
  logic [CW-1:0]   r_cnt;

  logic [W:0]      w_add;
  logic [W:0]      w_sub;
  logic [W:0]      w_msum;
  logic [W:0]      w_rsh;
  logic [W-1:0]    w_rdif;
  logic            w_rge;
  logic [W-1:0]    w_hi_nxt;
  logic [W-1:0]    w_lo_nxt;
  logic            w_trap;

  assign w_add = {1'b0, a} + {1'b0, b};
  assign w_sub = {1'b0, a} - {1'b0, b};

  // Mul keeps {hi,lo} as the running product with the multiplier shifting out of lo.
  assign w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);

  // Div: hi is the remainder, lo shifts the dividend out and the quotient in.
  assign w_rsh  = {r_hi, r_lo[W-1]};
  assign w_rge  = (w_rsh >= {1'b0, r_b});
  assign w_rdif = w_rsh[W-1:0] - r_b;

`ifdef ALU_SEQ_DIV0_TRAP_EN
  assign w_trap = (b == '0);
`else
  assign w_trap = 1'b0;
`endif

  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_state == S_MUL) begin
      w_hi_nxt = w_msum[W:1];
      w_lo_nxt = {w_msum[0], r_lo[W-1:1]};
    end else if (r_state == S_DIV) begin
      w_hi_nxt = w_rge ? w_rdif : w_rsh[W-1:0];
      w_lo_nxt = {r_lo[W-2:0], w_rge};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
      ovf       <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            in_ready <= 1'b0;
            case (func)
              2'b00: begin
                out       <= {{W{1'b0}}, w_add[W-1:0]};
                ovf       <= w_add[W];
                out_valid <= 1'b1;
                r_state   <= S_DONE;
              end
              2'b01: begin
                out       <= {{W{1'b0}}, w_sub[W-1:0]};
                ovf       <= w_sub[W];
                out_valid <= 1'b1;
                r_state   <= S_DONE;
              end
              2'b10: begin
                r_hi    <= '0;
                r_lo    <= b;
                r_cnt   <= CW'(W);
                r_state <= S_MUL;
              end
              2'b11: begin
                if (w_trap) begin
                  out       <= '0;
                  ovf       <= 1'b1;
                  out_valid <= 1'b1;
                  r_state   <= S_DONE;
                end else begin
                  r_hi    <= '0;
                  r_lo    <= a;
                  r_cnt   <= CW'(W);
                  r_state <= S_DIV;
                end
              end
            endcase
          end
        end
        S_MUL, S_DIV: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            out       <= (r_state == S_MUL) ? {w_hi_nxt, w_lo_nxt} : {w_lo_nxt, w_hi_nxt};
            ovf       <= 1'b0;
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl (width=6): directed cases, backpressure, mid-op reset, random ops.
module tb_alu_seq_ctrl;

  localparam int W = 6;
  localparam int M = 1 << W;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic [1:0]      func;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  out;
  logic            ovf;

  alu_seq_ctrl #(.width(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .func     (func),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .ovf      (ovf)
  );

  typedef struct {
    logic [2*W-1:0] out;
    logic           ovf;
    int             lat;
    int             acc;
    bit             seen;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   acc_cnt = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_vec = 0;
  bit   rdy_rand = 0;
  bit   rdy_fix = 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
    end
  end

  task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int ia, input int ib, input int f);
    exp_t e;
    e.seen = 0;
    e.acc  = 0;
    case (f)
      0: begin e.out = (2*W)'((ia + ib) % M); e.ovf = (ia + ib) >= M; e.lat = 1; end
      1: begin e.out = (2*W)'((ia - ib + M) % M); e.ovf = ia < ib; e.lat = 1; end
      2: begin e.out = (2*W)'(ia * ib); e.ovf = 1'b0; e.lat = W + 1; end
      default: begin
        if (ib == 0) begin
`ifdef ALU_SEQ_DIV0_TRAP_EN
          e.out = '0; e.ovf = 1'b1; e.lat = 1;
`else
          e.out = (2*W)'((M - 1) * M + ia); e.ovf = 1'b0; e.lat = W + 1;
`endif
        end else begin
          e.out = (2*W)'((ia / ib) * M + (ia % ib)); e.ovf = 1'b0; e.lat = W + 1;
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: predicts accepts from the model's own busy state and checks every presented result.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      bit was_busy;
      exp_t e;
      was_busy = (q.size() != 0);
      chk("in_ready", (2*W)'(in_ready), (2*W)'(!was_busy));
      if (!was_busy) begin
        if (out_valid) chk("spurious_out_valid", (2*W)'(out_valid), '0);
        if (in_valid) begin
          e = model(int'(a), int'(b), int'(func));
          e.acc = cyc + 1;
          q.push_back(e);
          acc_cnt++;
        end
      end else if (out_valid) begin
        if (!q[0].seen) begin
          chk("latency", (2*W)'(cyc - q[0].acc + 1), (2*W)'(q[0].lat));
          q[0].seen = 1;
        end
        chk("out", out, q[0].out);
        chk("ovf", (2*W)'(ovf), (2*W)'(q[0].ovf));
        if (out_ready) void'(q.pop_front());
      end else if (q[0].seen) begin
        chk("out_valid_dropped", (2*W)'(out_valid), (2*W)'(1));
        void'(q.pop_front());
      end
    end
  end

  task automatic issue(input int ia, input int ib, input int f);
    int start;
    int k;
    start    = acc_cnt;
    k        = 0;
    a        = W'(ia);
    b        = W'(ib);
    func     = 2'(f);
    in_valid = 1'b1;
    while (acc_cnt == start && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (acc_cnt == start) chk("accept_timeout", (2*W)'(0), (2*W)'(1));
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    func     = 2'($urandom);
    n_vec++;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", (2*W)'(q.size()), '0);
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    func     = '0;
    #12;
    chk("rst_in_ready", (2*W)'(in_ready), (2*W)'(1));
    chk("rst_out_valid", (2*W)'(out_valid), '0);
    chk("rst_out", out, '0);
    chk("rst_ovf", (2*W)'(ovf), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases with the consumer always ready.
    issue(50, 20, 0);
    issue(5, 9, 1);
    issue(63, 63, 2);
    issue(45, 7, 3);
    issue(5, 9, 3);
    issue(13, 0, 3);
    issue(0, 0, 1);
    issue(63, 1, 0);
    wait_idle();

    // Backpressure with stray in_valid pulses while a result is pending.
    rdy_fix = 1'b0;
    @(posedge clk);
    #1;
    issue(3, 4, 2);
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (!out_valid) chk("bp_out_valid_timeout", (2*W)'(out_valid), (2*W)'(1));
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a        = W'($urandom);
      b        = W'($urandom);
      func     = 2'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rdy_fix  = 1'b1;
    wait_idle();

    // Reset in the middle of a multiply.
    issue(7, 9, 2);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", (2*W)'(out_valid), '0);
    chk("midrst_out", out, '0);
    chk("midrst_in_ready", (2*W)'(in_ready), (2*W)'(1));
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(1, 1, 0);
    wait_idle();

    // Randomised traffic with a random consumer.
    rdy_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      int rb;
      rb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, M - 1));
      issue(int'($urandom_range(0, M - 1)), rb, int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    wait_idle();
    rdy_rand = 1'b0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
